// File: rtl/melody_pkg.sv
// melody_pkg: note codes, tone frequency table, half-period helper and FSM states
package melody_pkg;
  typedef logic [3:0] note_t;
  typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;
  localparam int unsigned NOTE_HZ [16] = '{0, 262, 277, 294, 311, 330, 349, 370,
                                           392, 415, 440, 466, 494, 523, 587, 659};
  function automatic int unsigned half_period(int unsigned clk_hz, note_t n);
    int unsigned hp;
    hp = (NOTE_HZ[n] == 0) ? 1 : clk_hz / (2 * NOTE_HZ[n]);
    return (hp == 0) ? 1 : hp;
  endfunction
endpackage

// File: rtl/mb_debounce.sv
// mb_debounce: two-flop synchroniser followed by a stability-count debouncer
module mb_debounce #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic s1, s2;
  logic [CW-1:0] cnt;
  // sync chain; dout follows s2 once it has differed for DEB_CYCLES cycles in a row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      dout <= 1'b1;
      cnt  <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 == dout) cnt <= '0;
      else if (cnt == CW'(DEB_CYCLES - 1)) begin
        dout <= s2;
        cnt  <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/melody_box.sv
// melody_box: live key tones or a stored melody as a square wave on the speaker pin
module melody_box
  import melody_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned NUM_KEYS = 3,
  parameter logic [4*NUM_KEYS-1:0] KEY_NOTES = {4'd12, 4'd14, 4'd1},
  parameter int unsigned SEQ_LEN = 3,
  parameter logic [4*SEQ_LEN-1:0] SEQ_NOTES = {4'd12, 4'd14, 4'd1},
  parameter int unsigned DEB_CYCLES = 1_000_000,
  parameter int unsigned NOTE_CYCLES = 12_500_000,
  parameter int unsigned GAP_CYCLES = 1_250_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic                play_n,
  input  logic                mode,
  output logic                spk,
  output logic                busy,
  output logic [3:0]          cur_note
);
  logic [NUM_KEYS-1:0] key_d;
  logic play_d, mode_d, play_q, mode_q, press, mode_chg, last;
  logic [31:0] hp_tab [16];
  note_t seq_tab [16];
  state_t state, state_n;
  logic [3:0] step, step_n;
  logic [31:0] tmr, tmr_n, tcnt;
  note_t live, nxt_note;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    mb_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (.clk(clk), .rst_n(rst_n), .din(key_n[g]), .dout(key_d[g]));
  end
  mb_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_play (.clk(clk), .rst_n(rst_n), .din(play_n), .dout(play_d));
  mb_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode (.clk(clk), .rst_n(rst_n), .din(mode), .dout(mode_d));

  for (genvar g = 0; g < 16; g++) begin : g_tab
    assign hp_tab[g] = half_period(CLK_HZ, note_t'(g));
    if (g < SEQ_LEN) begin : g_seq
      assign seq_tab[g] = SEQ_NOTES[4*g +: 4];
    end else begin : g_pad
      assign seq_tab[g] = '0;
    end
  end

  assign press    = play_q & ~play_d;
  assign mode_chg = mode_d ^ mode_q;
  assign last     = step == 4'(SEQ_LEN - 1);
  assign busy     = state != IDLE;

  // live note: lowest-index pressed key wins
  always_comb begin
    live = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (!key_d[i]) live = KEY_NOTES[4*i +: 4];
  end

  // melody sequencer next state; mode changes and live mode hold it in IDLE
  always_comb begin
    state_n = state;
    step_n  = step;
    tmr_n   = tmr;
    if (mode_chg || !mode_d) begin
      state_n = IDLE;
      step_n  = '0;
      tmr_n   = '0;
    end else begin
      unique case (state)
        IDLE: if (press) begin
          state_n = NOTE;
          step_n  = '0;
          tmr_n   = '0;
        end
        NOTE: if (press) begin
          state_n = IDLE;
          tmr_n   = '0;
        end else if (tmr == NOTE_CYCLES - 1) begin
          tmr_n   = '0;
          state_n = (GAP_CYCLES != 0) ? GAP : last ? IDLE : NOTE;
          step_n  = (GAP_CYCLES != 0 || last) ? step : step + 1'b1;
        end else tmr_n = tmr + 1;
        GAP: if (press) begin
          state_n = IDLE;
          tmr_n   = '0;
        end else if (tmr == GAP_CYCLES - 1) begin
          tmr_n   = '0;
          state_n = last ? IDLE : NOTE;
          step_n  = last ? step : step + 1'b1;
        end else tmr_n = tmr + 1;
        default: state_n = IDLE;
      endcase
    end
    nxt_note = mode_chg ? '0 : !mode_d ? live : (state_n == NOTE) ? seq_tab[step_n] : '0;
  end

  // sequencer and edge-detect registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      step   <= '0;
      tmr    <= '0;
      play_q <= 1'b1;
      mode_q <= 1'b1;
    end else begin
      state  <= state_n;
      step   <= step_n;
      tmr    <= tmr_n;
      play_q <= play_d;
      mode_q <= mode_d;
    end
  end

  // tone generator; a note change or rest restarts the phase with spk low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_note <= '0;
      tcnt     <= '0;
      spk      <= 1'b0;
    end else begin
      cur_note <= nxt_note;
      if (nxt_note != cur_note || nxt_note == '0) begin
        tcnt <= '0;
        spk  <= 1'b0;
      end else if (tcnt == hp_tab[cur_note] - 1) begin
        tcnt <= '0;
        spk  <= ~spk;
      end else tcnt <= tcnt + 1;
    end
  end
endmodule
